proc_mem_bridge: RTL and testbench

Memory stage on the processor's bus: owns the 256 × 16 program/data store, answers processor fetches and loads on `din`, and commits processor stores from `dout`. On reset it holds the processor in reset and accepts a program image over a valid/ready load port. It then releases the processor and services its `adrs`/`rw`/`dout` requests with one-cycle read latency.

---
 rtl/proc_bus_pkg.sv | 21 ++
 rtl/mem_array.sv | 57 +++++
 rtl/proc_mem_bridge.sv | 141 ++++++++++++++
 tb/tb_proc_mem_bridge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_bus_pkg.sv
// rtl/proc_bus_pkg.sv - shared processor bus types and constants
//
// Purpose: FSM state encoding for the memory bridge, bus direction
// encodings and the default bus widths shared with the processor top.
// Ports: none (package).
package proc_bus_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;
  localparam int DEF_BW = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous write-first RAM
//
// Purpose: 2**AW x DW storage with a registered read port.
// Ports:
//   clk    in   clock, rising edge
//   clr    in   async active-low reset (read register only, not contents)
//   we     in   write enable
//   re     in   read enable; when low, rdata holds its value
//   addr   in   AW  word address
//   wdata  in   DW  write data
//   rdata  out  DW  registered read data
module mem_array
  import proc_bus_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // Contents are deliberately not reset so a partial reload keeps old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Write-first: a write in the same cycle as an enabled read returns the
  // new word rather than the old contents.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = we ? wdata : mem[addr];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/proc_mem_bridge.sv
// rtl/proc_mem_bridge.sv - boot loader and memory stage for the processor bus
//
// Purpose: holds the processor in reset while a program image is streamed
// into memory over the load port, then releases the processor and serves
// its reads/writes with one-cycle read latency.
// Ports:
//   clk       in   clock, rising edge
//   clr       in   async active-low reset
//   adrs      in   AW  processor address
//   rw        in   processor direction (1 read, 0 write)
//   dout      in   BW  processor store data
//   din       out  DW  registered read data to processor
//   cpu_clr   out  active-low reset to processor
//   ld_valid  in   load word offered
//   ld_ready  out  load word accepted
//   ld_data   in   DW  load word
//   ld_last   in   final load word marker
//   ld_done   out  high once RUN is reached
module proc_mem_bridge
  import proc_bus_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int BW      = DEF_BW,
  parameter bit LOAD_EN = 1'b1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] adrs,
  input  logic          rw,
  input  logic [BW-1:0] dout,
  output logic [DW-1:0] din,
  output logic          cpu_clr,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_done
);

  localparam logic [AW-1:0] PTR_MAX     = '1;
  localparam state_e        RESET_STATE = LOAD_EN ? LOAD : START;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ld_ready_q, ld_ready_d;
  logic          cpu_clr_q, cpu_clr_d;
  logic          ld_done_q, ld_done_d;

  logic          ld_xfer;
  logic          run;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  assign run     = (state_q == RUN);
  assign ld_xfer = (state_q == LOAD) && ld_valid && ld_ready_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      LOAD: begin
        if (ld_xfer) begin
          // The image ends on ld_last or when the store is full; either way
          // the pointer is left at 0 for the next boot.
          if (ld_last || (ptr_q == PTR_MAX)) begin
            state_d = START;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      START:   state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RESET_STATE;
    endcase

    // ld_ready looks ahead so it drops on the edge that takes the last word
    // and no extra word can slip in.
    ld_ready_d = (state_d == LOAD);
    // cpu_clr/ld_done follow the current state, so the processor leaves
    // reset one cycle after the bridge itself is in RUN.
    cpu_clr_d  = run;
    ld_done_d  = run;
  end

  // Single memory port: processor owns it in RUN, load port otherwise.
  // Only processor accesses update the read register, so din holds its
  // value through LOAD and START.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = ptr_q;
    mem_wdata = ld_data;
    if (run) begin
      mem_addr  = adrs;
      mem_re    = 1'b1;
      mem_we    = (rw == RW_WRITE);
      mem_wdata = DW'(dout);
    end else if (ld_xfer) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= RESET_STATE;
      ptr_q      <= '0;
      ld_ready_q <= 1'b0;
      cpu_clr_q  <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ld_ready_q <= ld_ready_d;
      cpu_clr_q  <= cpu_clr_d;
      ld_done_q  <= ld_done_d;
    end
  end

  mem_array #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk  (clk),
    .clr  (clr),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(din)
  );

  assign ld_ready = ld_ready_q;
  assign cpu_clr  = cpu_clr_q;
  assign ld_done  = ld_done_q;

endmodule

// File: tb/tb_proc_mem_bridge.sv
// tb/tb_proc_mem_bridge.sv - scoreboard bench for proc_mem_bridge
module tb_proc_mem_bridge;
  import proc_bus_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, rw, ld_valid, ld_last;
  logic [7:0]  adrs, dout;
  logic [15:0] ld_data, din;
  logic        cpu_clr, ld_ready, ld_done;

  logic        clr1;
  logic [15:0] din1;
  logic        cpu_clr1, ld_ready1, ld_done1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic        drv_din = 1'b0;
  logic        rd_seen = 1'b0;

  proc_mem_bridge u_dut (
    .clk     (clk),
    .clr     (clr),
    .adrs    (adrs),
    .rw      (rw),
    .dout    (dout),
    .din     (din),
    .cpu_clr (cpu_clr),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_data (ld_data),
    .ld_last (ld_last),
    .ld_done (ld_done)
  );

  proc_mem_bridge #(.LOAD_EN(1'b0)) u_dut_noload (
    .clk     (clk),
    .clr     (clr1),
    .adrs    (8'h00),
    .rw      (RW_READ),
    .dout    (8'h00),
    .din     (din1),
    .cpu_clr (cpu_clr1),
    .ld_valid(1'b1),
    .ld_ready(ld_ready1),
    .ld_data (16'hFFFF),
    .ld_last (1'b1),
    .ld_done (ld_done1)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any cycle in which the bench drove a processor access must be
  // followed by din matching the oldest queued expectation.
  always @(posedge clk) rd_seen <= drv_din;

  always @(negedge clk) begin
    if (rd_seen) begin
      logic [15:0] e;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL din_unexpected: got %h expected no access", din);
      end else begin
        e = exp_q.pop_front();
        check("din", din, e);
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic last);
    int t = 0;
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    while (ld_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("ld_ready_timeout", {15'd0, ld_ready}, 16'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input logic [7:0] a, input logic r, input logic [7:0] d,
                        input logic [15:0] exp);
    @(negedge clk);
    adrs    = a;
    rw      = r;
    dout    = d;
    drv_din = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    drv_din = 1'b0;
    rw      = RW_READ;
  endtask

  task automatic wait_run();
    int t = 0;
    while (cpu_clr !== 1'b1 && t < 10) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("cpu_clr_run", {15'd0, cpu_clr}, 16'd1);
    check("ld_done_run", {15'd0, ld_done}, 16'd1);
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    check("queue_empty", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    clr = 1'b0; clr1 = 1'b0;
    adrs = 8'h00; rw = RW_READ; dout = 8'h00;
    ld_valid = 1'b0; ld_data = 16'h0000; ld_last = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ld_ready", {15'd0, ld_ready}, 16'd0);
    check("rst_cpu_clr",  {15'd0, cpu_clr},  16'd0);
    check("rst_ld_done",  {15'd0, ld_done},  16'd0);
    check("rst_din",      din,               16'h0000);

    // Boot with a 3-word image.
    @(negedge clk) clr = 1'b1;
    @(posedge clk);
    #1;
    check("ld_ready_rise", {15'd0, ld_ready}, 16'd1);
    send(16'hA080, 1'b0);
    send(16'h400F, 1'b0);
    @(negedge clk) ld_valid = 1'b0;
    @(negedge clk);
    send(16'h0000, 1'b1);
    check("ld_ready_fall", {15'd0, ld_ready}, 16'd0);
    check("cpu_clr_edge0", {15'd0, cpu_clr},  16'd0);
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("din_hold_start", din, 16'h0000);
    @(posedge clk);
    #1;
    check("cpu_clr_edge1", {15'd0, cpu_clr}, 16'd0);
    @(posedge clk);
    #1;
    check("cpu_clr_edge2", {15'd0, cpu_clr}, 16'd1);
    check("ld_done_edge2", {15'd0, ld_done}, 16'd1);
    check("ld_ready_run",  {15'd0, ld_ready}, 16'd0);

    // Processor reads and write-first stores.
    cpu_op(8'h01, RW_READ,  8'h00, 16'h400F);
    cpu_op(8'h00, RW_READ,  8'h00, 16'hA080);
    cpu_op(8'h81, RW_WRITE, 8'h33, 16'h0033);
    cpu_op(8'h80, RW_WRITE, 8'h5A, 16'h005A);
    cpu_op(8'h80, RW_READ,  8'h00, 16'h005A);
    cpu_op(8'h81, RW_READ,  8'h00, 16'h0033);
    cpu_op(8'h02, RW_READ,  8'h00, 16'h0000);
    drain();

    // Full 256-word image without ld_last.
    @(negedge clk) clr = 1'b0;
    #1;
    check("abort_ld_ready", {15'd0, ld_ready}, 16'd0);
    check("abort_cpu_clr",  {15'd0, cpu_clr},  16'd0);
    check("abort_din",      din,               16'h0000);
    @(negedge clk) clr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(16'hC000 + 16'(i), 1'b0);
    end
    check("full_ld_ready_fall", {15'd0, ld_ready}, 16'd0);
    @(negedge clk) ld_valid = 1'b0;
    wait_run();
    cpu_op(8'hFF, RW_READ, 8'h00, 16'hC0FF);
    cpu_op(8'h07, RW_READ, 8'h00, 16'hC007);
    cpu_op(8'h80, RW_READ, 8'h00, 16'hC080);
    cpu_op(8'h00, RW_READ, 8'h00, 16'hC000);
    drain();

    // Reset after two words, then a one-word reload.
    @(negedge clk) clr = 1'b0;
    @(negedge clk) clr = 1'b1;
    send(16'hBEEF, 1'b0);
    send(16'hCAFE, 1'b0);
    @(negedge clk);
    clr      = 1'b0;
    ld_valid = 1'b0;
    #1;
    check("midload_ld_ready", {15'd0, ld_ready}, 16'd0);
    @(negedge clk) clr = 1'b1;
    send(16'h1234, 1'b1);
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    wait_run();
    cpu_op(8'h00, RW_READ, 8'h00, 16'h1234);
    cpu_op(8'h01, RW_READ, 8'h00, 16'hCAFE);
    cpu_op(8'h02, RW_READ, 8'h00, 16'hC002);
    drain();

    // LOAD_EN = 0 instance: no load phase at all.
    check("noload_rst_cpu_clr",  {15'd0, cpu_clr1},  16'd0);
    check("noload_rst_ld_ready", {15'd0, ld_ready1}, 16'd0);
    @(negedge clk) clr1 = 1'b1;
    @(posedge clk);
    #1;
    check("noload_cpu_clr_edge1",  {15'd0, cpu_clr1},  16'd0);
    check("noload_ld_ready_edge1", {15'd0, ld_ready1}, 16'd0);
    @(posedge clk);
    #1;
    check("noload_cpu_clr_edge2", {15'd0, cpu_clr1}, 16'd1);
    check("noload_ld_done_edge2", {15'd0, ld_done1}, 16'd1);
    repeat (4) @(posedge clk);
    #1;
    check("noload_ld_ready_late", {15'd0, ld_ready1}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
